// File: rtl/mem_pc_redirect.sv
// -----------------------------------------------------------------------------
// mem_pc_redirect
//
// Registered PC-redirect unit in the MEM stage. It picks the next PC from the
// resolved control-flow sources, holds it toward fetch with a valid/ready
// handshake, and then raises a wrong-path flush for FLUSH_CYC cycles.
// Source priority: jump-register > J-type jump > taken branch.
//
// Parameters:
//   ADDR_W     PC/data width (must be >= JIDX_W+2)
//   JIDX_W     J-type instruction index width
//   FLUSH_CYC  flush cycles after fetch accepts a redirect (1..15)
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_valid          MEM-stage instruction is valid
//   i_pc4            PC+4 of the MEM-stage instruction
//   i_addr_branch    computed branch target
//   i_data_rs        rs value, used as the jr target
//   i_addr_JumpAddr  J-type instruction index
//   i_con_branch     branch resolved as taken
//   i_con_jump       J/JAL
//   i_con_jumpr      JR/JALR
//   i_fetch_ready    fetch accepts the redirect this cycle
//   o_redirect_valid redirect pending toward fetch
//   o_addr_JBpc      redirect target, stable while o_redirect_valid is high
//   o_flush          squash younger IF/ID/EX instructions
//   o_busy           unit is not idle
//   o_misalign       misaligned jr target seen (ARC_PCSEL_ALIGN_CHK_EN only)
//
// Build option:
//   ARC_PCSEL_ALIGN_CHK_EN  when defined, a winning jr with a misaligned target
//                           is rejected and reported on o_misalign; when
//                           undefined, the jr target is word-aligned by
//                           clearing its two low bits.
// -----------------------------------------------------------------------------
module mem_pc_redirect #(
  parameter int ADDR_W    = 32,
  parameter int JIDX_W    = 26,
  parameter int FLUSH_CYC = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_pc4,
  input  logic [ADDR_W-1:0] i_addr_branch,
  input  logic [ADDR_W-1:0] i_data_rs,
  input  logic [JIDX_W-1:0] i_addr_JumpAddr,
  input  logic              i_con_branch,
  input  logic              i_con_jump,
  input  logic              i_con_jumpr,
  input  logic              i_fetch_ready,
  output logic              o_redirect_valid,
  output logic [ADDR_W-1:0] o_addr_JBpc,
  output logic              o_flush,
  output logic              o_busy
`ifdef ARC_PCSEL_ALIGN_CHK_EN
  ,
  output logic              o_misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LD = FLUSH_CYC[3:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              req;
  logic              rejectJr;
  logic [ADDR_W-1:0] jumpTarget;
  logic [ADDR_W-1:0] jrTarget;
  logic [ADDR_W-1:0] selTarget;
  logic              unusedBits;

  assign req = i_valid & (i_con_jumpr | i_con_jump | i_con_branch);

  // J-type target keeps the PC region bits above the index field. When the
  // index field fills the whole PC there are no region bits left to keep.
  generate
    if (ADDR_W > JIDX_W + 2) begin : gen_region
      assign jumpTarget = {i_pc4[ADDR_W-1:JIDX_W+2], i_addr_JumpAddr, 2'b00};
    end else begin : gen_noregion
      assign jumpTarget = {i_addr_JumpAddr, 2'b00};
    end
  endgenerate

`ifdef ARC_PCSEL_ALIGN_CHK_EN
  logic misalign_q, misalign_d;

  // Misaligned jr targets are refused rather than silently fixed up.
  assign jrTarget   = i_data_rs;
  assign rejectJr   = i_con_jumpr & (|i_data_rs[1:0]);
  assign unusedBits = ^i_pc4[JIDX_W+1:0];
  assign o_misalign = misalign_q;
`else
  // Without the check, the jr target is forced onto a word boundary.
  assign jrTarget   = {i_data_rs[ADDR_W-1:2], 2'b00};
  assign rejectJr   = 1'b0;
  assign unusedBits = ^{i_pc4[JIDX_W+1:0], i_data_rs[1:0]};
`endif

  // Source priority mux: jr wins over jump, jump wins over branch.
  always_comb begin
    selTarget = i_addr_branch;
    if (i_con_jumpr) begin
      selTarget = jrTarget;
    end else if (i_con_jump) begin
      selTarget = jumpTarget;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE; anything arriving
  // while holding or flushing belongs to the wrong path and is dropped.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
`ifdef ARC_PCSEL_ALIGN_CHK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          if (rejectJr) begin
`ifdef ARC_PCSEL_ALIGN_CHK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            target_d = selTarget;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_fetch_ready) begin
          cnt_d   = FLUSH_LD;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The count of 1 marks the last flush cycle.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, held target and flush counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= 4'd0;
`ifdef ARC_PCSEL_ALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
`ifdef ARC_PCSEL_ALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign o_redirect_valid = (state_q == HOLD);
  assign o_flush          = (state_q != IDLE);
  assign o_busy           = (state_q != IDLE);
  assign o_addr_JBpc      = target_q;

endmodule

// File: tb/tb_mem_pc_redirect.sv
// -----------------------------------------------------------------------------
// tb_mem_pc_redirect
//
// Directed testbench for mem_pc_redirect with default parameters
// (ADDR_W=32, JIDX_W=26, FLUSH_CYC=3). Each scenario task drives its own
// stimulus and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_pc_redirect;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_pc4;
  logic [31:0] i_addr_branch;
  logic [31:0] i_data_rs;
  logic [25:0] i_addr_JumpAddr;
  logic        i_con_branch;
  logic        i_con_jump;
  logic        i_con_jumpr;
  logic        i_fetch_ready;
  logic        o_redirect_valid;
  logic [31:0] o_addr_JBpc;
  logic        o_flush;
  logic        o_busy;
`ifdef ARC_PCSEL_ALIGN_CHK_EN
  logic        o_misalign;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  mem_pc_redirect #(
    .ADDR_W   (32),
    .JIDX_W   (26),
    .FLUSH_CYC(3)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_valid         (i_valid),
    .i_pc4           (i_pc4),
    .i_addr_branch   (i_addr_branch),
    .i_data_rs       (i_data_rs),
    .i_addr_JumpAddr (i_addr_JumpAddr),
    .i_con_branch    (i_con_branch),
    .i_con_jump      (i_con_jump),
    .i_con_jumpr     (i_con_jumpr),
    .i_fetch_ready   (i_fetch_ready),
    .o_redirect_valid(o_redirect_valid),
    .o_addr_JBpc     (o_addr_JBpc),
    .o_flush         (o_flush),
    .o_busy          (o_busy)
`ifdef ARC_PCSEL_ALIGN_CHK_EN
    ,
    .o_misalign      (o_misalign)
`endif
  );

  // Free-running clock, 10 time-unit period.
  always #5 i_clk = ~i_clk;

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle, so outputs are read away from the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clearInputs();
    i_valid         = 1'b0;
    i_pc4           = '0;
    i_addr_branch   = '0;
    i_data_rs       = '0;
    i_addr_JumpAddr = '0;
    i_con_branch    = 1'b0;
    i_con_jump      = 1'b0;
    i_con_jumpr     = 1'b0;
    i_fetch_ready   = 1'b0;
  endtask

  // Accept any pending redirect and step until the unit is idle again.
  task automatic drainToIdle();
    i_fetch_ready = 1'b1;
    for (int c = 0; c < 30 && o_busy !== 1'b0; c++) begin
      step();
    end
    i_fetch_ready = 1'b0;
  endtask

  // Power-on reset, then a reset asserted asynchronously in the middle of HOLD.
  task automatic test_reset();
    clearInputs();
    i_rst_n = 1'b0;
    #12;
    testsRun++;
    if ({o_redirect_valid, o_flush, o_busy} !== 3'b000 || o_addr_JBpc !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_init: valid/flush/busy=%b addr=%h, required 000 and 00000000",
               {o_redirect_valid, o_flush, o_busy}, o_addr_JBpc);
    end
`ifdef ARC_PCSEL_ALIGN_CHK_EN
    testsRun++;
    if (o_misalign !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_misalign: got %b, required 0", o_misalign);
    end
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();

    i_valid       = 1'b1;
    i_con_branch  = 1'b1;
    i_addr_branch = 32'h0000_0040;
    step();
    clearInputs();
    testsRun++;
    if (o_redirect_valid !== 1'b1 || o_addr_JBpc !== 32'h0000_0040) begin
      testsFailed++;
      $display("[TB] FAIL reset_pre_hold: valid=%b addr=%h, required 1 and 00000040",
               o_redirect_valid, o_addr_JBpc);
    end
    #3;
    i_rst_n = 1'b0;
    #1;
    testsRun++;
    if ({o_redirect_valid, o_flush, o_busy} !== 3'b000 || o_addr_JBpc !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_async: valid/flush/busy=%b addr=%h, required 000 and 00000000",
               {o_redirect_valid, o_flush, o_busy}, o_addr_JBpc);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    step();
    testsRun++;
    if ({o_redirect_valid, o_flush, o_busy} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_after: valid/flush/busy=%b, required 000",
               {o_redirect_valid, o_flush, o_busy});
    end
  endtask

  // J-type target keeps pc4[31:28] and appends the index shifted by two.
  task automatic test_jump_target();
    i_valid         = 1'b1;
    i_con_jump      = 1'b1;
    i_pc4           = 32'hA000_0008;
    i_addr_JumpAddr = 26'h000_0010;
    step();
    clearInputs();
    testsRun++;
    if (o_redirect_valid !== 1'b1 || o_flush !== 1'b1 || o_addr_JBpc !== 32'hA000_0040) begin
      testsFailed++;
      $display("[TB] FAIL jump_target: valid=%b flush=%b addr=%h, required 1 1 a0000040",
               o_redirect_valid, o_flush, o_addr_JBpc);
    end
    drainToIdle();
    testsRun++;
    if (o_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL jump_drain: busy=%b, required 0", o_busy);
    end
  endtask

  // All three controls at once: jr must win.
  task automatic test_priority();
    i_valid         = 1'b1;
    i_con_jumpr     = 1'b1;
    i_con_jump      = 1'b1;
    i_con_branch    = 1'b1;
    i_data_rs       = 32'h0040_0100;
    i_pc4           = 32'h1000_0000;
    i_addr_JumpAddr = 26'h000_0123;
    i_addr_branch   = 32'h0000_5550;
    step();
    clearInputs();
    testsRun++;
    if (o_redirect_valid !== 1'b1 || o_addr_JBpc !== 32'h0040_0100) begin
      testsFailed++;
      $display("[TB] FAIL priority_jr: valid=%b addr=%h, required 1 00400100",
               o_redirect_valid, o_addr_JBpc);
    end
    drainToIdle();

    // Jump beats branch when jr is absent.
    i_valid         = 1'b1;
    i_con_jump      = 1'b1;
    i_con_branch    = 1'b1;
    i_pc4           = 32'h1000_0000;
    i_addr_JumpAddr = 26'h000_0123;
    i_addr_branch   = 32'h0000_5550;
    step();
    clearInputs();
    testsRun++;
    if (o_addr_JBpc !== 32'h1000_048C) begin
      testsFailed++;
      $display("[TB] FAIL priority_jump: addr=%h, required 1000048c", o_addr_JBpc);
    end
    drainToIdle();
  endtask

  // Four cycles of backpressure, then accept; a request during FLUSH is dropped.
  task automatic test_backpressure();
    int validCycles = 0;
    int flushCycles = 0;
    int addrBad     = 0;
    i_valid       = 1'b1;
    i_con_branch  = 1'b1;
    i_addr_branch = 32'h0000_1000;
    step();
    clearInputs();
    for (int c = 0; c < 30 && o_flush === 1'b1; c++) begin
      if (o_redirect_valid === 1'b1) begin
        validCycles++;
        if (o_addr_JBpc !== 32'h0000_1000) addrBad++;
      end
      flushCycles++;
      i_fetch_ready = (c >= 4);
      i_valid       = (c == 5);
      i_con_branch  = (c == 5);
      i_addr_branch = 32'h0000_2000;
      step();
    end
    clearInputs();
    testsRun++;
    if (validCycles != 5) begin
      testsFailed++;
      $display("[TB] FAIL bp_valid_len: got %0d cycles, required 5", validCycles);
    end
    testsRun++;
    if (flushCycles != 8) begin
      testsFailed++;
      $display("[TB] FAIL bp_flush_len: got %0d cycles, required 8", flushCycles);
    end
    testsRun++;
    if (addrBad != 0) begin
      testsFailed++;
      $display("[TB] FAIL bp_target_stable: %0d cycles off target, required 0", addrBad);
    end
    step();
    testsRun++;
    if (o_redirect_valid !== 1'b0 || o_busy !== 1'b0 || o_addr_JBpc !== 32'h0000_1000) begin
      testsFailed++;
      $display("[TB] FAIL bp_flush_req_ignored: valid=%b busy=%b addr=%h, required 0 0 00001000",
               o_redirect_valid, o_busy, o_addr_JBpc);
    end
  endtask

  // Request in the first idle cycle, with ready already high (ignored in IDLE).
  task automatic test_back_to_back();
    i_valid       = 1'b1;
    i_con_branch  = 1'b1;
    i_addr_branch = 32'h0000_0800;
    step();
    clearInputs();
    drainToIdle();
    i_valid       = 1'b1;
    i_con_branch  = 1'b1;
    i_addr_branch = 32'h0000_3000;
    i_fetch_ready = 1'b1;
    step();
    i_valid      = 1'b0;
    i_con_branch = 1'b0;
    testsRun++;
    if (o_redirect_valid !== 1'b1 || o_addr_JBpc !== 32'h0000_3000) begin
      testsFailed++;
      $display("[TB] FAIL b2b_accept: valid=%b addr=%h, required 1 00003000",
               o_redirect_valid, o_addr_JBpc);
    end
    step();
    testsRun++;
    if (o_redirect_valid !== 1'b0 || o_flush !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_handshake: valid=%b flush=%b, required 0 1",
               o_redirect_valid, o_flush);
    end
    clearInputs();
    drainToIdle();
  endtask

  // jr to a target whose low bits are not zero.
  task automatic test_alignment();
    i_valid     = 1'b1;
    i_con_jumpr = 1'b1;
    i_data_rs   = 32'h0000_0102;
    step();
    clearInputs();
`ifdef ARC_PCSEL_ALIGN_CHK_EN
    testsRun++;
    if (o_misalign !== 1'b1 || o_redirect_valid !== 1'b0 || o_busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL align_reject: misalign=%b valid=%b busy=%b, required 1 0 0",
               o_misalign, o_redirect_valid, o_busy);
    end
    step();
    testsRun++;
    if (o_misalign !== 1'b0 || o_redirect_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL align_pulse: misalign=%b valid=%b, required 0 0",
               o_misalign, o_redirect_valid);
    end
`else
    testsRun++;
    if (o_redirect_valid !== 1'b1 || o_addr_JBpc !== 32'h0000_0100) begin
      testsFailed++;
      $display("[TB] FAIL align_force: valid=%b addr=%h, required 1 00000100",
               o_redirect_valid, o_addr_JBpc);
    end
    drainToIdle();
`endif
  endtask

  initial begin
    test_reset();
    test_jump_target();
    test_priority();
    test_backpressure();
    test_back_to_back();
    test_alignment();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
